axi_sram_slave: RTL
===================

# axi_sram_slave

AXI3 slave that consumes the CPU core's external AXI master port and serves it from a single-port synchronous SRAM. It is the on-board memory model for the core's bus in simulation and FPGA bring-up. One transaction is in flight at a time. Reads and writes share the SRAM port under round-robin arbitration. INCR and FIXED bursts up to 16 beats are supported.

## Interface
Parameters:
- ADDR_W, 16: SRAM word-address width; capacity is 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address channel; arlock/arcache/arprot accepted and ignored.
- arvalid  in  1 / arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1 / rready  in  1
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address channel; awlock/awcache/awprot ignored.
- awvalid  in  1 / awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1 / wready  out  1; wid is ignored.
- bid/bresp/bvalid  out  4/2/1 / bready  in  1
- ram_en  out  1  SRAM access strobe.
- ram_wen  out  4  byte write enables; 0 means read.
- ram_addr  out  ADDR_W  word address.
- ram_wdata  out  32  write data.
- ram_rdata  in  32  read data, valid one cycle after ram_en with ram_wen=0.

## Operation
- FSM states:
  - IDLE: no transaction; address channels may be accepted.
  - RD_REQ: drive one SRAM read.
  - RD_RESP: hold the R beat until rready.
  - WR_DATA: accept W beats.
  - WR_RESP: hold the B response until bready.
- IDLE arbitration:
  - grant_wr = awvalid & (!arvalid | last_rd).
  - awready = IDLE & grant_wr; arready = IDLE & !grant_wr.
  - arready and awready are never high together.
  - last_rd is set on an AR handshake, cleared on an AW handshake, and resets to 0, so a read wins the first collision.
- AR handshake: latch id, addr, len, size, burst; beat counter := 0; go to RD_REQ.
- RD_REQ: ram_en=1, ram_wen=0, ram_addr=addr[ADDR_W+1:2]; go to RD_RESP.
- RD_RESP:
  - rvalid=1; rdata is registered from ram_rdata and held stable until the handshake.
  - rresp=OKAY; rlast=(beat==len).
  - On handshake: if rlast go to IDLE, else advance address, beat++, go to RD_REQ.
- AW handshake: latch fields; go to WR_DATA.
- WR_DATA:
  - wready=1.
  - Each W handshake writes the same cycle: ram_en=1, ram_wen=wstrb, ram_wdata=wdata. Then advance address and beat.
  - The burst ends on a beat with wlast=1, or after beat len even if wlast=0.
  - Set err if wlast disagrees with (beat==len).
  - At burst end go to WR_RESP.
- WR_RESP: bvalid=1, bid=latched awid, bresp=SLVERR if err else OKAY. On handshake go to IDLE and clear err.
- Address advance:
  - INCR adds 2^size bytes.
  - FIXED holds the address.
  - WRAP is treated as INCR.
  - Byte address is 32-bit modulo; only bits [ADDR_W+1:2] reach the SRAM, so memory aliases.
- Narrow transfers: reads return the full aligned word; writes rely on wstrb.
- size>2 is an error:
  - Read: every beat returns rdata=0, rresp=SLVERR; RD_REQ issues no ram_en.
  - Write: beats are accepted without SRAM writes; bresp=SLVERR.
- Unused outputs (rid/bid/rdata/ram_*) hold their last value; ram_en and ram_wen are 0 when not accessing.

## Timing
- While reset is high: arready, awready, wready, rvalid, bvalid, ram_en are 0 and ram_wen=0; other outputs are 0. The FSM is in IDLE.
- A reset asserted mid-burst aborts the transaction with no response; the first cycle after reset is IDLE.
- Read latency: AR handshake at cycle N, ram_en at N+1, rvalid at N+2. Each subsequent beat's rvalid comes 2 cycles after the prior R handshake.
- Write: W accepted from the cycle after the AW handshake, one beat per cycle at full rate. bvalid in the cycle after the last W handshake.
- Return to IDLE in the cycle after the final R/B handshake; the next AR/AW can be accepted that cycle.
- All valid outputs are stable until handshake; no combinational path from rready/bready/wvalid to any valid output. arready/awready depend combinationally on arvalid/awvalid (permitted by AXI).

## Structure
- Package axi_sram_pkg: resp codes (OKAY=2'b00, SLVERR=2'b10), burst codes (FIXED=0, INCR=1, WRAP=2), FSM state encoding.
- Sub-module axi_beat_addr_gen: combinational next-address from addr/size/burst. It is shared by the read and write paths.

## Test plan
- Single read: arlen=0, araddr=0x10, mem[4]=0xDEADBEEF → rvalid at N+2, rdata=0xDEADBEEF, rlast=1, rresp=0, rid=AR id.
- 4-beat INCR read from 0x100 with rready low for 3 cycles on beat 2 → rdata holds mem[0x40..0x43] in order; rlast only on beat 3; no ram_en while stalled.
- Write with wstrb=4'b0101, wdata=0xAABBCCDD to 0x20 (old 0x11223344) → mem[8]=0x11BB33DD; bvalid next cycle, bresp=0.
- AR and AW valid in the same cycle after reset → read granted first; the next collision grants write.
- Write burst awlen=1 with wlast=1 on beat 0 → one SRAM write, bresp=SLVERR; arsize=3 read → rresp=SLVERR, rdata=0, no ram_en.
- Reset asserted during beat 2 of a 4-beat read → rvalid=0 immediately; a read issued after reset completes normally.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// Shared constants and FSM encoding for the AXI3-to-SRAM slave.
package axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_WR_DATA,
        ST_WR_RESP
    } state_e;

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Next-beat byte address for one AXI burst; WRAP is deliberately treated as INCR.
module axi_beat_addr_gen
    import axi_sram_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    always_comb begin
        next_addr = addr;
        if (burst != BURST_FIXED) begin
            next_addr = addr + (32'd1 << size);
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI3 slave serving reads and writes from a single-port synchronous SRAM.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_e              state_q, state_d;
    logic                last_rd_q, last_rd_d;
    logic [31:0]         addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [7:0]          beat_q, beat_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rd_fresh_q, rd_fresh_d;
    logic [3:0]          rid_q, rid_d;
    logic [3:0]          bid_q, bid_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;

    logic [31:0] next_addr;
    logic        grant_wr, size_err, last_beat;
    logic        unused_ok;

    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    assign grant_wr  = awvalid & (~arvalid | last_rd_q);
    assign size_err  = (size_q > 3'd2);
    assign last_beat = (beat_q == len_q);

    axi_beat_addr_gen u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_comb begin
        state_d     = state_q;
        last_rd_d   = last_rd_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        rd_fresh_d  = 1'b0;
        rid_d       = rid_q;
        bid_d       = bid_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        arready     = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        rvalid      = 1'b0;
        bvalid      = 1'b0;
        ram_en      = 1'b0;
        ram_wen     = '0;

        unique case (state_q)
            ST_IDLE: begin
                awready = grant_wr;
                arready = ~grant_wr;
                if (arvalid && arready) begin
                    rid_d     = arid;
                    addr_d    = araddr;
                    len_d     = arlen;
                    size_d    = arsize;
                    burst_d   = arburst;
                    beat_d    = '0;
                    last_rd_d = 1'b1;
                    state_d   = ST_RD_REQ;
                end else if (awvalid && awready) begin
                    bid_d     = awid;
                    addr_d    = awaddr;
                    len_d     = awlen;
                    size_d    = awsize;
                    burst_d   = awburst;
                    beat_d    = '0;
                    err_d     = (awsize > 3'd2);
                    last_rd_d = 1'b0;
                    state_d   = ST_WR_DATA;
                end
            end
            ST_RD_REQ: begin
                if (!size_err) begin
                    ram_en     = 1'b1;
                    ram_addr_d = addr_q[ADDR_W+1:2];
                end
                rd_fresh_d = 1'b1;
                state_d    = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                rvalid = 1'b1;
                // SRAM data is only valid in the first RESP cycle; it is forwarded then and held after.
                if (rd_fresh_q) begin
                    rdata_d = size_err ? '0 : ram_rdata;
                end
                if (rready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = next_addr;
                        beat_d  = beat_q + 8'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    if (!size_err) begin
                        ram_en      = 1'b1;
                        ram_wen     = wstrb;
                        ram_addr_d  = addr_q[ADDR_W+1:2];
                        ram_wdata_d = wdata;
                    end
                    addr_d = next_addr;
                    beat_d = beat_q + 8'd1;
                    if (wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (wlast || last_beat) begin
                        state_d = ST_WR_RESP;
                    end
                end
            end
            ST_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reset) begin
            arready = 1'b0;
            awready = 1'b0;
            wready  = 1'b0;
            rvalid  = 1'b0;
            bvalid  = 1'b0;
            ram_en  = 1'b0;
            ram_wen = '0;
        end
    end

    assign rdata     = reset ? '0 : rdata_d;
    assign rresp     = (rvalid && size_err) ? RESP_SLVERR : RESP_OKAY;
    assign rlast     = rvalid & last_beat;
    assign rid       = reset ? '0 : rid_q;
    assign bid       = reset ? '0 : bid_q;
    assign bresp     = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign ram_addr  = reset ? '0 : ram_addr_d;
    assign ram_wdata = reset ? '0 : ram_wdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_rd_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            rd_fresh_q  <= 1'b0;
            rid_q       <= '0;
            bid_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_rd_q   <= last_rd_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rd_fresh_q  <= rd_fresh_d;
            rid_q       <= rid_d;
            bid_q       <= bid_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

endmodule
